// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM stage / load-store unit: load opcodes,
// stall-bus polarity and the load-wait state encoding.
package mem_stage_lsu_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

    localparam int   STALL_BUS_W = 6;
    localparam logic STOP        = 1'b1;
    localparam logic NO_STOP     = 1'b0;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_WAIT,
        LSU_HAVE
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Selects the addressed byte/half/word out of a raw memory word and
// sign- or zero-extends it to XLEN.
module mem_stage_lsu_load_align
    import mem_stage_lsu_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int LANE_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]   raw,
    input  logic [2:0]        op,
    input  logic [LANE_W-1:0] lane,
    output logic [XLEN-1:0]   value
);

    // Word lanes only exist on a 64-bit datapath; on 32-bit the word is always lane 0.
    localparam logic [LANE_W-1:0] W_MASK = (XLEN == 64) ? LANE_W'(4) : '0;

    logic [7:0]        b_val;
    logic [15:0]       h_val;
    logic [31:0]       w_val;
    logic [LANE_W-1:0] h_lane;
    logic [LANE_W-1:0] w_lane;

    function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] zext8(input logic [7:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    always_comb begin
        h_lane = {lane[LANE_W-1:1], 1'b0};
        w_lane = lane & W_MASK;
        b_val  = raw[{lane, 3'b000} +: 8];
        h_val  = raw[{h_lane, 3'b000} +: 16];
        w_val  = raw[{w_lane, 3'b000} +: 32];
        value  = raw;
        case (op)
            LD_LB:   value = sext8(b_val);
            LD_LBU:  value = zext8(b_val);
            LD_LH:   value = sext16(h_val);
            LD_LHU:  value = zext16(h_val);
            LD_LW:   value = sext32(w_val);
            LD_LWU:  value = (XLEN == 64) ? zext32(w_val) : sext32(w_val);
            LD_LD:   value = (XLEN == 64) ? raw : sext32(w_val);
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds the EX->MEM payload, waits for variable-latency
// load data, aligns it and drives the WB and ID-bypass buses.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int RF_AW   = 5,
    parameter  int HILO_W  = 64,
    parameter  int STALL_W = STALL_BUS_W,
    parameter  int MEM_IDX = 3,
    localparam int LANE_W  = $clog2(XLEN / 8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic               ex_rf_we,
    input  logic [RF_AW-1:0]   ex_rf_waddr,
    input  logic [XLEN-1:0]    ex_result,
    input  logic               ex_ld,
    input  logic [2:0]         ex_ld_op,
    input  logic [LANE_W-1:0]  ex_addr_lo,
    input  logic [HILO_W-1:0]  ex_hilo,
    input  logic               dmem_rvalid,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               stallreq_mem,
    output logic               wb_valid,
    output logic [31:0]        wb_pc,
    output logic               wb_rf_we,
    output logic [RF_AW-1:0]   wb_rf_waddr,
    output logic [XLEN-1:0]    wb_wdata,
    output logic [HILO_W-1:0]  wb_hilo,
    output logic               fwd_we,
    output logic [RF_AW-1:0]   fwd_waddr,
    output logic [XLEN-1:0]    fwd_wdata,
    output logic               fwd_ready
);

    typedef struct packed {
        logic [31:0]       pc;
        logic              rf_we;
        logic [RF_AW-1:0]  waddr;
        logic [XLEN-1:0]   result;
        logic              ld;
        logic [2:0]        ld_op;
        logic [LANE_W-1:0] addr_lo;
        logic [HILO_W-1:0] hilo;
    } mem_pay_t;

    logic       vld_p1;
    mem_pay_t   pay_p1;
    lsu_state_e state;
    logic       drop_pend;
    logic [XLEN-1:0] rbuf;
    logic [XLEN-1:0] raw_word;
    logic [XLEN-1:0] aligned;

    logic advance, bubble, overwrite, in_wait, rv_eff, pending;
    logic unused_stall;

    assign unused_stall = ^stall_i;
    assign advance   = (stall_i[MEM_IDX] == NO_STOP);
    assign bubble    = (stall_i[MEM_IDX] == STOP) && (stall_i[MEM_IDX+1] == NO_STOP);
    assign overwrite = flush_i || advance || bubble;
    assign in_wait   = (state == LSU_WAIT);
    // A response arriving while a drop is owed belongs to the killed load.
    assign rv_eff    = dmem_rvalid && !drop_pend;
    assign pending   = in_wait && !rv_eff;

    // ---- EX -> MEM register and load-wait FSM ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            pay_p1    <= '0;
            state     <= LSU_IDLE;
            drop_pend <= 1'b0;
            rbuf      <= '0;
        end else begin
            if (flush_i || bubble) begin
                vld_p1 <= 1'b0;
                pay_p1 <= '0;
            end else if (advance) begin
                vld_p1 <= ex_valid;
                pay_p1 <= '{pc: ex_pc, rf_we: ex_rf_we, waddr: ex_rf_waddr,
                            result: ex_result, ld: ex_ld, ld_op: ex_ld_op,
                            addr_lo: ex_addr_lo, hilo: ex_hilo};
            end

            if (flush_i || bubble)
                state <= LSU_IDLE;
            else if (advance)
                state <= (ex_valid && ex_ld) ? LSU_WAIT : LSU_IDLE;
            else if (in_wait && rv_eff)
                state <= LSU_HAVE;

            if (in_wait && rv_eff)
                rbuf <= dmem_rdata;

            // Killing a load whose data is still outstanding owes one discarded response.
            if (pending && overwrite)
                drop_pend <= 1'b1;
            else if (dmem_rvalid && drop_pend)
                drop_pend <= 1'b0;
        end
    end

    // ---- MEM -> WB / bypass outputs ----
    assign raw_word = in_wait ? dmem_rdata : rbuf;

    mem_stage_lsu_load_align #(.XLEN(XLEN)) u_align (
        .raw   (raw_word),
        .op    (pay_p1.ld_op),
        .lane  (pay_p1.addr_lo),
        .value (aligned)
    );

    assign stallreq_mem = pending;
    assign wb_valid     = vld_p1 && !pending;
    assign wb_pc        = pay_p1.pc;
    assign wb_rf_we     = pay_p1.rf_we;
    assign wb_rf_waddr  = pay_p1.waddr;
    assign wb_wdata     = pay_p1.ld ? aligned : pay_p1.result;
    assign wb_hilo      = pay_p1.hilo;
    assign fwd_we       = vld_p1 && pay_p1.rf_we;
    assign fwd_waddr    = pay_p1.waddr;
    assign fwd_wdata    = wb_wdata;
    assign fwd_ready    = vld_p1 && !pending;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu (XLEN=32): alignment vector table, directed
// multi-cycle sequences, and a randomized run against a slot/latency model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_result;
    logic        ex_ld;
    logic [2:0]  ex_ld_op;
    logic [1:0]  ex_addr_lo;
    logic [63:0] ex_hilo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stallreq_mem, wb_valid, wb_rf_we, fwd_we, fwd_ready;
    logic [31:0] wb_pc, wb_wdata, fwd_wdata;
    logic [4:0]  wb_rf_waddr, fwd_waddr;
    logic [63:0] wb_hilo;

    int checks = 0;
    int failures = 0;

    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_EX   = 6'b001111;
    localparam logic [5:0] ST_MEM  = 6'b011111;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result), .ex_ld(ex_ld),
        .ex_ld_op(ex_ld_op), .ex_addr_lo(ex_addr_lo), .ex_hilo(ex_hilo),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stallreq_mem(stallreq_mem), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_wdata(wb_wdata),
        .wb_hilo(wb_hilo), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_ready(fwd_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  lane;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          valid;
        bit          rf_we;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic [31:0] pc;
        bit          ld;
        logic [2:0]  op;
        logic [1:0]  lane;
    } instr_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = ST_NONE; flush_i = 1'b0;
        ex_valid = 1'b0; ex_pc = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
        ex_result = '0; ex_ld = 1'b0; ex_ld_op = '0; ex_addr_lo = '0; ex_hilo = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    task automatic issue_load(input logic [2:0] op, input logic [1:0] lane, input logic [4:0] rd);
        idle();
        ex_valid = 1'b1; ex_ld = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = rd;
        ex_ld_op = op; ex_addr_lo = lane; ex_result = 32'h5A5A_5A5A; ex_pc = 32'h400;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, wb_valid, 0);
        chk({tag, "_we"}, {wb_rf_we, fwd_we}, 0);
        chk({tag, "_data"}, {wb_wdata, fwd_wdata}, 0);
        chk({tag, "_pc_hilo"}, {wb_pc, wb_hilo[31:0]}, 0);
        chk({tag, "_ctl"}, {stallreq_mem, fwd_ready, wb_rf_waddr}, 0);
    endtask

    // Reference extraction: plain shift/mask arithmetic, sign handled by subtraction.
    function automatic logic [31:0] model_load(input logic [2:0] op, input int lane, input logic [31:0] w);
        logic [31:0] v;
        case (op)
            3'd0, 3'd4: begin
                v = (w >> (8 * lane)) & 32'hFF;
                if (op == 3'd0 && v >= 32'h80) v = v - 32'h100;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * (lane / 2))) & 32'hFFFF;
                if (op == 3'd1 && v >= 32'h8000) v = v - 32'h1_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.valid  = ($urandom_range(0, 4) != 0);
        t.ld     = t.valid && ($urandom_range(0, 1) == 1);
        t.rf_we  = ($urandom_range(0, 3) != 0);
        t.waddr  = 5'($urandom_range(0, 31));
        t.result = $urandom;
        t.pc     = $urandom;
        t.op     = 3'($urandom_range(0, 6));
        t.lane   = 2'($urandom_range(0, 3));
        return t;
    endfunction

    vec_t   vecs[12];
    instr_t ex_q, slot;
    bit     slot_have, mem_busy, rv, pend, exp_v;
    int     wait_left;
    logic [31:0] slot_data, mdata;
    logic [5:0]  stl;

    initial begin
        vecs[0]  = '{3'b000, 2'd2, 32'h80FF_0000, 32'hFFFF_FFFF};
        vecs[1]  = '{3'b100, 2'd2, 32'h80FF_0000, 32'h0000_00FF};
        vecs[2]  = '{3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[3]  = '{3'b100, 2'd0, 32'h1234_5678, 32'h0000_0078};
        vecs[4]  = '{3'b001, 2'd0, 32'h1234_8765, 32'hFFFF_8765};
        vecs[5]  = '{3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001};
        vecs[6]  = '{3'b001, 2'd2, 32'h7FFF_0000, 32'h0000_7FFF};
        vecs[7]  = '{3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[8]  = '{3'b011, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[9]  = '{3'b110, 2'd0, 32'h89AB_CDEF, 32'h89AB_CDEF};
        vecs[10] = '{3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F};
        vecs[11] = '{3'b101, 2'd0, 32'hFFFF_FFFF, 32'h0000_FFFF};

        // Reset with live-looking inputs: everything must read zero.
        idle();
        rst = 1'b1;
        ex_valid = 1'b1; ex_rf_we = 1'b1; ex_result = 32'hFFFF_FFFF; ex_pc = 32'h1;
        tick(); tick();
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        idle();
        tick();

        // ALU op r5 = 0x1234.
        idle();
        ex_valid = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd5; ex_result = 32'h1234;
        ex_pc = 32'h100; ex_hilo = 64'h1111_2222_3333_4444;
        tick();
        idle(); #1;
        chk("alu_valid", {wb_valid, wb_rf_we, fwd_we, fwd_ready}, 4'b1111);
        chk("alu_waddr", {wb_rf_waddr, fwd_waddr}, {5'd5, 5'd5});
        chk("alu_wdata", wb_wdata, 32'h1234);
        chk("alu_fwd_wdata", fwd_wdata, 32'h1234);
        chk("alu_pc_hilo", {wb_pc, wb_hilo}, {32'h100, 64'h1111_2222_3333_4444});
        tick();

        // Alignment table: each load answered in the first wait cycle.
        for (int i = 0; i < 12; i++) begin
            issue_load(vecs[i].op, vecs[i].lane, 5'(i + 1));
            tick();
            idle(); dmem_rvalid = 1'b1; dmem_rdata = vecs[i].rdata; #1;
            chk("tbl_stallreq", stallreq_mem, 0);
            chk("tbl_valid", {wb_valid, fwd_ready}, 2'b11);
            chk("tbl_wdata", wb_wdata, vecs[i].exp);
            tick();
        end

        // LB lane 2 with three-cycle latency.
        issue_load(3'b000, 2'd2, 5'd8);
        tick();
        for (int c = 0; c < 3; c++) begin
            idle(); stall_i = ST_MEM; #1;
            chk("lat3_stallreq", stallreq_mem, 1);
            chk("lat3_wait_valid", {wb_valid, fwd_ready}, 2'b00);
            tick();
        end
        idle(); dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000; #1;
        chk("lat3_release", {stallreq_mem, wb_valid}, 2'b01);
        chk("lat3_wdata", wb_wdata, 32'hFFFF_FFFF);
        tick();

        // Data arrives while WB is stalled: value must come from the buffer afterwards.
        issue_load(3'b010, 2'd0, 5'd9);
        tick();
        idle(); stall_i = ST_MEM; #1;
        chk("have_wait", stallreq_mem, 1);
        tick();
        idle(); stall_i = ST_MEM; dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF; #1;
        chk("have_rv_wdata", wb_wdata, 32'h1357_9BDF);
        chk("have_rv_stallreq", stallreq_mem, 0);
        tick();
        idle(); stall_i = ST_MEM; dmem_rdata = 32'hFFFF_0000; #1;
        chk("have_hold_wdata", wb_wdata, 32'h1357_9BDF);
        chk("have_hold_ctl", {wb_valid, stallreq_mem, fwd_ready}, 3'b101);
        tick();
        idle(); dmem_rdata = 32'h0F0F_0F0F; #1;
        chk("have_release_wdata", wb_wdata, 32'h1357_9BDF);
        tick();
        idle(); #1;
        chk("have_after_valid", wb_valid, 0);

        // Flush during WAIT: the late response for the killed load is dropped.
        issue_load(3'b010, 2'd0, 5'd6);
        tick();
        idle(); stall_i = ST_MEM; flush_i = 1'b1; #1;
        chk("flush_wait_stallreq", stallreq_mem, 1);
        tick();
        issue_load(3'b010, 2'd0, 5'd7); #1;
        chk("flush_cleared", wb_valid, 0);
        tick();
        idle(); stall_i = ST_MEM; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_DEAD; #1;
        chk("drop_stallreq", stallreq_mem, 1);
        chk("drop_valid", wb_valid, 0);
        tick();
        idle(); dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_BEEF; #1;
        chk("drop_second_ctl", {stallreq_mem, wb_valid}, 2'b01);
        chk("drop_second_wdata", {wb_rf_waddr, wb_wdata}, {5'd7, 32'h0000_BEEF});
        tick();

        // EX stall with WB free inserts a bubble.
        idle();
        ex_valid = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd9; ex_result = 32'hABCD;
        tick();
        idle(); stall_i = ST_EX; ex_valid = 1'b1; ex_rf_we = 1'b1; ex_result = 32'h7777; #1;
        chk("bubble_before", {wb_valid, fwd_we, wb_wdata}, {2'b11, 32'hABCD});
        tick();
        idle(); stall_i = ST_EX; #1;
        chk("bubble_valid", {wb_valid, fwd_we}, 2'b00);
        tick();

        // Reset in the middle of a load wait.
        issue_load(3'b010, 2'd0, 5'd3);
        tick();
        idle(); stall_i = ST_MEM; rst = 1'b1;
        tick();
        rst = 1'b0; idle(); #1;
        chk_all_zero("rst_wait");
        tick();

        // Reset must also forget an owed drop.
        issue_load(3'b010, 2'd0, 5'd3);
        tick();
        idle(); stall_i = ST_MEM; flush_i = 1'b1;
        tick();
        idle(); rst = 1'b1;
        tick();
        rst = 1'b0;
        issue_load(3'b010, 2'd0, 5'd4);
        tick();
        idle(); dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_55AA; #1;
        chk("rst_drop_ctl", {stallreq_mem, wb_valid}, 2'b01);
        chk("rst_drop_wdata", wb_wdata, 32'h0000_55AA);
        tick();

        // Randomized run: bench acts as stall controller and data memory.
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        slot = '{default: 0}; slot_have = 0; slot_data = '0; mem_busy = 0; wait_left = 0;
        ex_q = rand_instr();
        for (int cyc = 0; cyc < 800; cyc++) begin
            rv    = mem_busy && (wait_left == 0);
            mdata = $urandom;
            pend  = slot.valid && slot.ld && !slot_have && !rv;
            if (pend) stl = ST_MEM;
            else case ($urandom_range(0, 5))
                0:       stl = ST_EX;
                1:       stl = ST_MEM;
                default: stl = ST_NONE;
            endcase
            stall_i = stl; flush_i = 1'b0;
            ex_valid = ex_q.valid; ex_pc = ex_q.pc; ex_rf_we = ex_q.rf_we;
            ex_rf_waddr = ex_q.waddr; ex_result = ex_q.result; ex_ld = ex_q.ld;
            ex_ld_op = ex_q.op; ex_addr_lo = ex_q.lane; ex_hilo = {ex_q.pc, ex_q.result};
            dmem_rvalid = rv; dmem_rdata = mdata;
            #1;
            exp_v = slot.valid && !pend;
            chk("rnd_stallreq", stallreq_mem, pend);
            chk("rnd_valid", {wb_valid, fwd_ready}, {exp_v, exp_v});
            if (exp_v) begin
                chk("rnd_wdata", wb_wdata,
                    slot.ld ? model_load(slot.op, int'(slot.lane), slot_have ? slot_data : mdata)
                            : slot.result);
                chk("rnd_dest", {wb_pc, wb_rf_waddr, fwd_we}, {slot.pc, slot.waddr, slot.rf_we});
            end
            if (rv) begin
                mem_busy = 0;
                if (slot.valid && slot.ld && !slot_have) begin
                    slot_have = 1; slot_data = mdata;
                end
            end else if (mem_busy) begin
                wait_left--;
            end
            if (stl[3] == 1'b0) begin
                slot = ex_q; slot_have = 0;
                if (ex_q.valid && ex_q.ld) begin
                    mem_busy = 1; wait_left = $urandom_range(0, 3);
                end
                ex_q = rand_instr();
            end else if (stl[4] == 1'b0) begin
                slot = '{default: 0}; slot_have = 0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
